alu_uart_sequencer: RTL and testbench

Control stage between the UART receiver/transmitter and the ALU.
- Collects three received bytes in order: operand A, operand B, opcode.
- Drives the registered operands and opcode into the ALU, then captures the ALU result.
- Hands the result to the UART transmitter using a start/done handshake.
- Replaces button-driven loading of A, B and opcode.

---
 rtl/alu_uart_pkg.sv | 26 ++
 rtl/byte_timer.sv | 33 +++
 rtl/alu_uart_sequencer.sv | 156 +++++++++++++++
 tb/tb_alu_uart_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_uart_pkg.sv
// Shared types and ALU opcode encodings for the UART-driven ALU sequencer.
package alu_uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    function automatic logic is_collecting(input state_t s);
        return (s == WAIT_B) || (s == WAIT_OP);
    endfunction

endpackage

// File: rtl/byte_timer.sv
// Saturating inter-byte idle counter; expired flags the last allowed idle cycle.
module byte_timer #(
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES) : '0;

    logic [CNT_W-1:0] count_r;

    // Idle counter: clear wins, then count while enabled, holding at the ceiling.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (TIMEOUT_CYCLES > 0) && enable && (count_r == CNT_LAST);

endmodule

// File: rtl/alu_uart_sequencer.sv
// Collects A, B and opcode bytes from the UART receiver, runs the ALU and
// hands its result to the UART transmitter with a start/done handshake.
module alu_uart_sequencer #(
    parameter int N_BITS         = 8,
    parameter int OP_BITS        = 6,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [N_BITS-1:0]  i_rx_data,
    input  logic               i_rx_done,
    input  logic [N_BITS-1:0]  i_alu_result,
    input  logic               i_tx_done,
    output logic [N_BITS-1:0]  o_data_a,
    output logic [N_BITS-1:0]  o_data_b,
    output logic [OP_BITS-1:0] o_opcode,
    output logic [N_BITS-1:0]  o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_timeout
);
    import alu_uart_pkg::*;

    state_t              state_r;
    state_t              state_next_s;
    logic [N_BITS-1:0]   data_a_r;
    logic [N_BITS-1:0]   data_b_r;
    logic [OP_BITS-1:0]  opcode_r;
    logic [N_BITS-1:0]   tx_data_r;
    logic                timeout_r;

    logic load_a_s;
    logic load_b_s;
    logic load_op_s;
    logic load_tx_s;
    logic timeout_s;
    logic timer_clear_s;
    logic timer_en_s;
    logic expired_s;

    byte_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_byte_timer (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .clear   (timer_clear_s),
        .enable  (timer_en_s),
        .expired (expired_s)
    );

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and load strobes; a byte arriving on the expiry cycle beats the timeout.
    always_comb begin
        state_next_s  = state_r;
        load_a_s      = 1'b0;
        load_b_s      = 1'b0;
        load_op_s     = 1'b0;
        load_tx_s     = 1'b0;
        timeout_s     = 1'b0;
        timer_clear_s = 1'b0;
        timer_en_s    = is_collecting(state_r) && !i_rx_done;
        case (state_r)
            IDLE: begin
                if (i_rx_done) begin
                    load_a_s      = 1'b1;
                    timer_clear_s = 1'b1;
                    state_next_s  = WAIT_B;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    load_b_s      = 1'b1;
                    timer_clear_s = 1'b1;
                    state_next_s  = WAIT_OP;
                end else if (expired_s) begin
                    timeout_s    = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_B;
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    load_op_s    = 1'b1;
                    state_next_s = EXEC;
                end else if (expired_s) begin
                    timeout_s    = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_OP;
                end
            end
            EXEC: begin
                load_tx_s    = 1'b1;
                state_next_s = SEND;
            end
            SEND: begin
                state_next_s = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_TX;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Operand, opcode, result and timeout-pulse registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            data_a_r  <= '0;
            data_b_r  <= '0;
            opcode_r  <= '0;
            tx_data_r <= '0;
            timeout_r <= 1'b0;
        end else begin
            if (load_a_s) begin
                data_a_r <= i_rx_data;
            end
            if (load_b_s) begin
                data_b_r <= i_rx_data;
            end
            if (load_op_s) begin
                opcode_r <= i_rx_data[OP_BITS-1:0];
            end
            if (load_tx_s) begin
                tx_data_r <= i_alu_result;
            end
            timeout_r <= timeout_s;
        end
    end

    assign o_data_a   = data_a_r;
    assign o_data_b   = data_b_r;
    assign o_opcode   = opcode_r;
    assign o_tx_data  = tx_data_r;
    assign o_timeout  = timeout_r;
    assign o_tx_start = (state_r == SEND);
    assign o_busy     = (state_r != IDLE);

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Self-checking bench: ALU in the loop, transaction-level reference model,
// directed scenarios with literal expectations plus a randomized soak.
module tb_alu_uart_sequencer;
    import alu_uart_pkg::*;

    localparam int T = 16;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b1;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_done = 1'b0;
    logic [7:0] i_alu_result;
    logic       i_tx_done = 1'b0;
    logic [7:0] o_data_a;
    logic [7:0] o_data_b;
    logic [5:0] o_opcode;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_busy;
    logic       o_timeout;

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SRA:  return $signed(a) >>> b;
            OP_SRL:  return a >> b;
            OP_NOR:  return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign i_alu_result = alu_ref(o_data_a, o_data_b, o_opcode);

    alu_uart_sequencer #(
        .N_BITS(8), .OP_BITS(6), .TIMEOUT_CYCLES(T)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_rx_data    (i_rx_data),
        .i_rx_done    (i_rx_done),
        .i_alu_result (i_alu_result),
        .i_tx_done    (i_tx_done),
        .o_data_a     (o_data_a),
        .o_data_b     (o_data_b),
        .o_opcode     (o_opcode),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .o_busy       (o_busy),
        .o_timeout    (o_timeout)
    );

    always #5 i_clock = ~i_clock;

    // Reference model: bytes collected so far, idle count, result pipeline countdown.
    int         m_have = 0;
    int         m_wait = 0;
    int         m_pipe = 0;   // 2: result being computed, 1: start request showing
    bit         m_txbusy = 1'b0;
    bit         m_to = 1'b0;
    bit         m_valid = 1'b0;
    logic [7:0] m_a, m_b, m_tx;
    logic [5:0] m_op;

    task automatic model_step();
        if (i_reset) begin
            m_have = 0; m_wait = 0; m_pipe = 0; m_txbusy = 1'b0; m_to = 1'b0;
            m_a = 8'h00; m_b = 8'h00; m_op = 6'h00; m_tx = 8'h00;
            m_valid = 1'b1;
        end else begin
            m_to = 1'b0;
            if (m_pipe == 2) begin
                m_tx = alu_ref(m_a, m_b, m_op);
                m_pipe = 1;
            end else if (m_pipe == 1) begin
                m_pipe = 0;
                m_txbusy = 1'b1;
            end else if (m_txbusy) begin
                if (i_tx_done) m_txbusy = 1'b0;
            end else if (i_rx_done) begin
                case (m_have)
                    0:       begin m_a = i_rx_data; m_have = 1; m_wait = 0; end
                    1:       begin m_b = i_rx_data; m_have = 2; m_wait = 0; end
                    default: begin m_op = i_rx_data[5:0]; m_have = 0; m_pipe = 2; end
                endcase
            end else if (m_have > 0) begin
                if (m_wait == T - 1) begin
                    m_have = 0;
                    m_to = 1'b1;
                end else begin
                    m_wait++;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge i_clock) begin
        if (m_valid) begin
            chk("data_a",   {24'h0, o_data_a},  {24'h0, m_a});
            chk("data_b",   {24'h0, o_data_b},  {24'h0, m_b});
            chk("opcode",   {26'h0, o_opcode},  {26'h0, m_op});
            chk("tx_data",  {24'h0, o_tx_data}, {24'h0, m_tx});
            chk("tx_start", {31'h0, o_tx_start}, {31'h0, (m_pipe == 1)});
            chk("busy",     {31'h0, o_busy},    {31'h0, (m_have > 0) || (m_pipe > 0) || m_txbusy});
            chk("timeout",  {31'h0, o_timeout}, {31'h0, m_to});
        end
    end

    task automatic tick();
        @(posedge i_clock);
        model_step();
        @(negedge i_clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] d);
        i_rx_data = d;
        i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
        i_rx_data = 8'($urandom);
    endtask

    task automatic pulse_reset();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
    endtask

    task automatic pulse_tx_done();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a"},     {24'h0, o_data_a}, 32'h0);
        chk({tag, "_b"},     {24'h0, o_data_b}, 32'h0);
        chk({tag, "_op"},    {26'h0, o_opcode}, 32'h0);
        chk({tag, "_tx"},    {24'h0, o_tx_data}, 32'h0);
        chk({tag, "_start"}, {31'h0, o_tx_start}, 32'h0);
        chk({tag, "_busy"},  {31'h0, o_busy}, 32'h0);
        chk({tag, "_to"},    {31'h0, o_timeout}, 32'h0);
    endtask

    // Called right after the opcode byte: EXEC now, SEND next, then handshake.
    task automatic finish_txn(input logic [7:0] exp_res, input int hold);
        chk("exec_no_start", {31'h0, o_tx_start}, 32'h0);
        tick();
        chk("start_at_t2", {31'h0, o_tx_start}, 32'h1);
        chk("result", {24'h0, o_tx_data}, {24'h0, exp_res});
        idle(hold);
        chk("result_held", {24'h0, o_tx_data}, {24'h0, exp_res});
        pulse_tx_done();
        chk("idle_after_tx_done", {31'h0, o_busy}, 32'h0);
    endtask

    task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                       input logic [7:0] exp_res, input int hold);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        finish_txn(exp_res, hold);
    endtask

    logic [5:0] ops [8];

    initial begin
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};
        idle(2);
        i_reset = 1'b0;
        chk_all_zero("reset");

        // Basic ADD
        txn(8'h05, 8'h03, 8'h20, 8'h08, 3);
        chk("add_a",  {24'h0, o_data_a}, 32'h05);
        chk("add_b",  {24'h0, o_data_b}, 32'h03);
        chk("add_op", {26'h0, o_opcode}, 32'h20);

        // SUB wrap then back-to-back OR
        txn(8'h03, 8'h05, 8'h22, 8'hFE, 2);
        txn(8'hF0, 8'h0F, 8'h25, 8'hFF, 1);

        // Timeout after one byte
        send_byte(8'h11);
        idle(T - 1);
        chk("to_not_yet", {31'h0, o_timeout}, 32'h0);
        chk("to_busy_before", {31'h0, o_busy}, 32'h1);
        tick();
        chk("to_pulse", {31'h0, o_timeout}, 32'h1);
        chk("to_idle", {31'h0, o_busy}, 32'h0);
        chk("to_a_kept", {24'h0, o_data_a}, 32'h11);
        tick();
        chk("to_single", {31'h0, o_timeout}, 32'h0);
        txn(8'h01, 8'h01, 8'h20, 8'h02, 1);

        // Byte in the last allowed idle cycle wins
        send_byte(8'h11);
        idle(T - 1);
        send_byte(8'h22);
        chk("edge_no_to", {31'h0, o_timeout}, 32'h0);
        chk("edge_busy", {31'h0, o_busy}, 32'h1);
        chk("edge_b", {24'h0, o_data_b}, 32'h22);
        send_byte(8'h20);
        finish_txn(8'h33, 1);

        // Dropped byte during WAIT_TX
        send_byte(8'h30);
        send_byte(8'h40);
        send_byte(8'h20);
        tick();
        tick();
        send_byte(8'hAA);
        idle(8);
        chk("drop_a", {24'h0, o_data_a}, 32'h30);
        chk("drop_tx", {24'h0, o_tx_data}, 32'h70);
        pulse_tx_done();
        send_byte(8'h07);
        chk("after_drop_a", {24'h0, o_data_a}, 32'h07);
        send_byte(8'h02);
        send_byte(8'h24);
        finish_txn(8'h02, 1);

        // Opcode truncation
        send_byte(8'h09);
        send_byte(8'h04);
        send_byte(8'hE2);
        chk("trunc_op", {26'h0, o_opcode}, 32'h22);
        finish_txn(8'h05, 2);

        // Reset in WAIT_OP, in EXEC and in SEND
        send_byte(8'h12);
        send_byte(8'h34);
        pulse_reset();
        chk_all_zero("rst_waitop");
        idle(3);
        chk("rst_waitop_quiet", {31'h0, o_tx_start}, 32'h0);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h20);
        pulse_reset();
        chk_all_zero("rst_exec");
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h20);
        tick();
        pulse_reset();
        chk_all_zero("rst_send");
        txn(8'h0A, 8'h05, 8'h26, 8'h0F, 2);

        // Randomized soak, checked cycle by cycle by the compare process
        begin
            int rx_pct;
            rx_pct = 40;
            for (int c = 0; c < 1500; c++) begin
                if (c % 64 == 0) rx_pct = ($urandom_range(0, 1) == 0) ? 40 : 3;
                i_reset   = ($urandom_range(0, 299) == 0);
                i_rx_done = ($urandom_range(0, 99) < rx_pct);
                i_tx_done = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 2) == 0)
                    i_rx_data = {2'($urandom), ops[$urandom_range(0, 7)]};
                else
                    i_rx_data = 8'($urandom);
                tick();
            end
            i_reset = 1'b0;
            i_rx_done = 1'b0;
            i_tx_done = 1'b0;
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
